// File: rtl/flush_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : flush_sequencer
//  Description : Recovers the pipeline after a committed mispredicted branch.
//                Latches the corrected PC, stalls commit, waits for committed
//                stores to drain, broadcasts a multi-cycle flush, then issues
//                a one-cycle redirect to the instruction fetcher.
//  Revision    : 1.0 - initial release
// ============================================================================
module flush_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_req_from_ro_buffer,
    input  logic [31:0]          next_pc_from_ro_buffer,
    input  logic                 store_pending_from_ls_buffer,
    output logic                 stall_to_ro_buffer,
    output logic                 flush_out,
    output logic                 redirect_to_inst_fetcher,
    output logic [31:0]          next_pc_to_inst_fetcher,
    output logic                 busy_out,
    output logic [CNT_WIDTH-1:0] flush_count_out
);

    // Value loaded into the flush down-counter; the last flush cycle is cnt == 0.
    localparam logic [3:0] c_flush_last = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_FLUSH    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [31:0]          r_pc;
    logic [CNT_WIDTH-1:0] r_flush_count;
    logic                 r_stall;
    logic                 r_flush;
    logic                 r_redirect;
    logic                 r_busy;

    // Sequencer FSM; every output is registered alongside the next state so
    // no input reaches an output combinationally. rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_pc          <= 32'd0;
            r_flush_count <= '0;
            r_stall       <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect    <= 1'b0;
            r_busy        <= 1'b0;
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (flush_req_from_ro_buffer) begin
                        r_pc    <= next_pc_from_ro_buffer;
                        r_state <= S_DRAIN;
                        r_stall <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Stores already committed must reach memory before the
                    // ls_buffer is flushed, so wait here with no timeout.
                    if (!store_pending_from_ls_buffer) begin
                        r_cnt   <= c_flush_last;
                        r_state <= S_FLUSH;
                        r_flush <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_REDIRECT;
                        r_flush    <= 1'b0;
                        r_redirect <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_REDIRECT: begin
                    if (r_flush_count != '1) begin
                        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
                    end
                    r_state    <= S_IDLE;
                    r_redirect <= 1'b0;
                    r_stall    <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_stall    <= 1'b0;
                    r_flush    <= 1'b0;
                    r_redirect <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign stall_to_ro_buffer       = r_stall;
    assign flush_out                = r_flush;
    assign redirect_to_inst_fetcher = r_redirect;
    assign next_pc_to_inst_fetcher  = r_pc;
    assign busy_out                 = r_busy;
    assign flush_count_out          = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_flush_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flush_sequencer
//  Description : Directed self-checking bench for flush_sequencer with a
//                redirect-PC scoreboard and a 2-bit-counter twin instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flush_sequencer;

    localparam int FC = 2;

    // {stall, flush, redirect, busy}
    localparam logic [3:0] V_IDLE  = 4'b0000;
    localparam logic [3:0] V_DRAIN = 4'b1001;
    localparam logic [3:0] V_FLUSH = 4'b1101;
    localparam logic [3:0] V_REDIR = 4'b1011;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        req;
    logic [31:0] pc_in;
    logic        sp;

    logic        stall, flush, redir, busy;
    logic [31:0] npc;
    logic [15:0] cnt;
    logic        s_stall, s_flush, s_redir, s_busy;
    logic [31:0] s_npc;
    logic [1:0]  s_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int model_cnt = 0;
    int model_sat = 0;
    logic [31:0] sb[$];

    always #5 clk_in = ~clk_in;

    flush_sequencer #(.FLUSH_CYCLES(FC), .CNT_WIDTH(16)) dut (
        .clk_in                       (clk_in),
        .rst_in                       (rst_in),
        .rdy_in                       (rdy_in),
        .flush_req_from_ro_buffer     (req),
        .next_pc_from_ro_buffer       (pc_in),
        .store_pending_from_ls_buffer (sp),
        .stall_to_ro_buffer           (stall),
        .flush_out                    (flush),
        .redirect_to_inst_fetcher     (redir),
        .next_pc_to_inst_fetcher      (npc),
        .busy_out                     (busy),
        .flush_count_out              (cnt)
    );

    flush_sequencer #(.FLUSH_CYCLES(FC), .CNT_WIDTH(2)) dut_sat (
        .clk_in                       (clk_in),
        .rst_in                       (rst_in),
        .rdy_in                       (rdy_in),
        .flush_req_from_ro_buffer     (req),
        .next_pc_from_ro_buffer       (pc_in),
        .store_pending_from_ls_buffer (sp),
        .stall_to_ro_buffer           (s_stall),
        .flush_out                    (s_flush),
        .redirect_to_inst_fetcher     (s_redir),
        .next_pc_to_inst_fetcher      (s_npc),
        .busy_out                     (s_busy),
        .flush_count_out              (s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, stall, flush, redir, busy}, {28'd0, exp});
    endtask

    // Scoreboard consumer: a redirect counts once per rdy-qualified cycle.
    always @(negedge clk_in) begin
        if (rst_in === 1'b1) begin
            if (flush && redir) chk("flush_redirect_overlap", 32'd1, 32'd0);
            if (redir && rdy_in) begin
                if (sb.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
                else                chk("redirect_pc", npc, sb.pop_front());
            end
        end
    end

    // One complete flush sequence with optional store drain, a second request
    // during DRAIN, and rdy_in drops in FLUSH and/or REDIRECT.
    task automatic do_flush(input logic [31:0] pc, input int drain, input bit second_req,
                            input int rdy_flush, input int rdy_redir);
        req = 1'b1; pc_in = pc; sp = (drain > 0);
        sb.push_back(pc);
        step();
        req = 1'b0;
        chk_out("drain_entry", V_DRAIN);
        if (second_req) begin
            req = 1'b1; pc_in = 32'h0000_DEAD;
        end
        for (int i = 0; i < drain; i++) begin
            step();
            req = 1'b0;
            chk_out("drain_hold", V_DRAIN);
        end
        sp = 1'b0;
        step();
        req = 1'b0;
        chk_out("flush_first", V_FLUSH);
        if (rdy_flush > 0) begin
            rdy_in = 1'b0;
            for (int i = 0; i < rdy_flush; i++) begin
                step();
                chk_out("flush_frozen", V_FLUSH);
            end
            rdy_in = 1'b1;
        end
        for (int i = 1; i < FC; i++) begin
            step();
            chk_out("flush_more", V_FLUSH);
        end
        step();
        chk_out("redirect", V_REDIR);
        chk("redirect_npc", npc, pc);
        chk("count_pre", {16'd0, cnt}, model_cnt);
        if (rdy_redir > 0) begin
            rdy_in = 1'b0;
            for (int i = 0; i < rdy_redir; i++) begin
                step();
                chk_out("redirect_frozen", V_REDIR);
                chk("count_frozen", {16'd0, cnt}, model_cnt);
            end
            rdy_in = 1'b1;
        end
        step();
        model_cnt = model_cnt + 1;
        if (model_sat < 3) model_sat = model_sat + 1;
        chk_out("back_idle", V_IDLE);
        chk("count_post", {16'd0, cnt}, model_cnt);
        chk("sat_count", {30'd0, s_cnt}, model_sat);
        chk("npc_held", npc, pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; req = 1'b0; pc_in = 32'h0; sp = 1'b0;

        // Reset held with requests pulsing
        for (int i = 0; i < 3; i++) begin
            req = i[0] ? 1'b0 : 1'b1; pc_in = 32'hABCD_0000 + i;
            step();
            chk_out("reset_outputs", V_IDLE);
            chk("reset_count", {16'd0, cnt}, 32'd0);
            chk("reset_npc", npc, 32'd0);
        end
        req = 1'b0;
        rst_in = 1'b1;
        step();
        chk_out("post_reset_idle", V_IDLE);
        step();
        chk_out("post_reset_idle2", V_IDLE);

        // Basic flush
        do_flush(32'h0000_1234, 0, 1'b0, 0, 0);
        // Store drain for 5 cycles
        do_flush(32'h0000_0080, 5, 1'b0, 0, 0);
        // Second request during DRAIN is ignored
        do_flush(32'h0000_4000, 0, 1'b1, 0, 0);
        chk("second_req_npc", npc, 32'h0000_4000);
        // rdy_in low during FLUSH, then separately during REDIRECT
        do_flush(32'h0000_5000, 0, 1'b0, 3, 0);
        do_flush(32'h0000_6000, 1, 1'b0, 0, 3);

        // Request while rdy_in low in IDLE is dropped
        rdy_in = 1'b0; req = 1'b1; pc_in = 32'h0000_7777;
        step();
        chk_out("rdy_low_req_dropped", V_IDLE);
        rdy_in = 1'b1; req = 1'b0;
        step();
        chk_out("rdy_low_req_still_idle", V_IDLE);
        chk("rdy_low_npc", npc, 32'h0000_6000);

        // Mid-sequence asynchronous reset while in FLUSH
        req = 1'b1; pc_in = 32'h0000_9999; sb.push_back(32'h0000_9999);
        step();
        req = 1'b0;
        step();
        chk_out("pre_reset_flush", V_FLUSH);
        rst_in = 1'b0;
        #1;
        chk_out("async_reset_clear", V_IDLE);
        chk("async_reset_count", {16'd0, cnt}, 32'd0);
        sb.delete();
        model_cnt = 0; model_sat = 0;
        step();
        step();
        rst_in = 1'b1;
        for (int i = 0; i < FC + 3; i++) begin
            step();
            chk_out("no_redirect_after_reset", V_IDLE);
        end
        chk("npc_after_reset", npc, 32'd0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            do_flush(32'h0001_0000 + 32'(i * 4), i % 2, 1'b0, 0, 0);
        end
        chk("sat_final", {30'd0, s_cnt}, 32'd3);
        chk("wide_final", {16'd0, cnt}, 32'd5);

        step();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
